// File: rtl/emif_avmm_arbiter.sv
// rtl/emif_avmm_arbiter.sv - two-requester round-robin Avalon-MM arbiter onto one EMIF port
// Read responses are steered back to their requester through an in-order owner tag FIFO.
module emif_avmm_arbiter #(
  parameter int RD_DEPTH = 8,
  parameter int ADDR_W   = 26,
  parameter int DATA_W   = 64
) (
  input  logic                      Clk_400,
  input  logic                      SoftReset_n,
  input  logic [ADDR_W-1:0]         m0_address,
  input  logic                      m0_read,
  input  logic                      m0_write,
  input  logic [DATA_W-1:0]         m0_writedata,
  input  logic [DATA_W/8-1:0]       m0_byteenable,
  output logic                      m0_waitrequest,
  output logic [DATA_W-1:0]         m0_readdata,
  output logic                      m0_readdatavalid,
  input  logic [ADDR_W-1:0]         m1_address,
  input  logic                      m1_read,
  input  logic                      m1_write,
  input  logic [DATA_W-1:0]         m1_writedata,
  input  logic [DATA_W/8-1:0]       m1_byteenable,
  output logic                      m1_waitrequest,
  output logic [DATA_W-1:0]         m1_readdata,
  output logic                      m1_readdatavalid,
  output logic [ADDR_W-1:0]         avs_address,
  output logic                      avs_read,
  output logic                      avs_write,
  output logic [DATA_W-1:0]         avs_writedata,
  output logic [DATA_W/8-1:0]       avs_byteenable,
  output logic [11:0]               avs_burstcount,
  input  logic                      avs_waitrequest,
  input  logic [DATA_W-1:0]         avs_readdata,
  input  logic                      avs_readdatavalid,
  output logic [$clog2(RD_DEPTH):0] rd_outstanding,
  output logic                      arb_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(RD_DEPTH) + 1;
  localparam int PTR_W = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RD_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RD_DEPTH - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   avs_address_q, avs_address_d;
  logic                avs_read_q, avs_read_d;
  logic                avs_write_q, avs_write_d;
  logic [DATA_W-1:0]   avs_writedata_q, avs_writedata_d;
  logic [BE_W-1:0]     avs_byteenable_q, avs_byteenable_d;
  logic [11:0]         avs_burstcount_q, avs_burstcount_d;
  logic                tag_q [RD_DEPTH];
  logic                tag_d [RD_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                m0_rvalid_q, m0_rvalid_d;
  logic                m1_rvalid_q, m1_rvalid_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;

  logic rd_ok, el0, el1, gnt, sel_rd, sel_wr, accept, push, pop, head;

  // A requester showing both read and write competes as a read.
  assign rd_ok  = cnt_q < CNT_MAX;
  assign el0    = m0_read ? rd_ok : m0_write;
  assign el1    = m1_read ? rd_ok : m1_write;
  assign gnt    = (el0 && el1) ? ~last_grant_q : el1;
  assign sel_rd = gnt ? m1_read : m0_read;
  assign sel_wr = gnt ? m1_write : m0_write;
  assign accept = (state_q == HOLD) && !avs_waitrequest;
  assign push   = accept && avs_read_q;
  assign pop    = avs_readdatavalid && (cnt_q != '0);
  assign head   = tag_q[rd_ptr_q];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    last_grant_d     = last_grant_q;
    avs_address_d    = avs_address_q;
    avs_read_d       = avs_read_q;
    avs_write_d      = avs_write_q;
    avs_writedata_d  = avs_writedata_q;
    avs_byteenable_d = avs_byteenable_q;
    avs_burstcount_d = avs_burstcount_q;
    tag_d            = tag_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    cnt_d            = cnt_q;
    err_d            = err_q;
    m0_rvalid_d      = 1'b0;
    m1_rvalid_d      = 1'b0;
    m0_rdata_d       = m0_rdata_q;
    m1_rdata_d       = m1_rdata_q;

    case (state_q)
      IDLE: begin
        if (el0 || el1) begin
          state_d          = HOLD;
          owner_d          = gnt;
          last_grant_d     = gnt;
          avs_address_d    = gnt ? m1_address : m0_address;
          avs_writedata_d  = gnt ? m1_writedata : m0_writedata;
          avs_byteenable_d = gnt ? m1_byteenable : m0_byteenable;
          avs_read_d       = sel_rd;
          avs_write_d      = sel_wr && !sel_rd;
          avs_burstcount_d = 12'd1;
          if (sel_rd && sel_wr) err_d = 1'b1;
        end
      end
      HOLD: begin
        if (!avs_waitrequest) begin
          state_d          = IDLE;
          avs_read_d       = 1'b0;
          avs_write_d      = 1'b0;
          avs_burstcount_d = 12'd0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      tag_d[wr_ptr_q] = owner_q;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push && !pop) cnt_d = cnt_q + CNT_ONE;
    else if (pop && !push) cnt_d = cnt_q - CNT_ONE;

    // Data arriving with no tag has no owner and is dropped.
    if (avs_readdatavalid && !pop) err_d = 1'b1;
    if (pop && !head) begin
      m0_rvalid_d = 1'b1;
      m0_rdata_d  = avs_readdata;
    end
    if (pop && head) begin
      m1_rvalid_d = 1'b1;
      m1_rdata_d  = avs_readdata;
    end
  end

  always_ff @(posedge Clk_400 or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      state_q          <= IDLE;
      owner_q          <= 1'b0;
      last_grant_q     <= 1'b1;
      avs_address_q    <= '0;
      avs_read_q       <= 1'b0;
      avs_write_q      <= 1'b0;
      avs_writedata_q  <= '0;
      avs_byteenable_q <= '0;
      avs_burstcount_q <= 12'd0;
      tag_q            <= '{default: 1'b0};
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      cnt_q            <= '0;
      err_q            <= 1'b0;
      m0_rvalid_q      <= 1'b0;
      m1_rvalid_q      <= 1'b0;
      m0_rdata_q       <= '0;
      m1_rdata_q       <= '0;
    end else begin
      state_q          <= state_d;
      owner_q          <= owner_d;
      last_grant_q     <= last_grant_d;
      avs_address_q    <= avs_address_d;
      avs_read_q       <= avs_read_d;
      avs_write_q      <= avs_write_d;
      avs_writedata_q  <= avs_writedata_d;
      avs_byteenable_q <= avs_byteenable_d;
      avs_burstcount_q <= avs_burstcount_d;
      tag_q            <= tag_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      cnt_q            <= cnt_d;
      err_q            <= err_d;
      m0_rvalid_q      <= m0_rvalid_d;
      m1_rvalid_q      <= m1_rvalid_d;
      m0_rdata_q       <= m0_rdata_d;
      m1_rdata_q       <= m1_rdata_d;
    end
  end

  assign m0_waitrequest   = !(accept && !owner_q);
  assign m1_waitrequest   = !(accept && owner_q);
  assign m0_readdata      = m0_rdata_q;
  assign m1_readdata      = m1_rdata_q;
  assign m0_readdatavalid = m0_rvalid_q;
  assign m1_readdatavalid = m1_rvalid_q;
  assign avs_address      = avs_address_q;
  assign avs_read         = avs_read_q;
  assign avs_write        = avs_write_q;
  assign avs_writedata    = avs_writedata_q;
  assign avs_byteenable   = avs_byteenable_q;
  assign avs_burstcount   = avs_burstcount_q;
  assign rd_outstanding   = cnt_q;
  assign arb_err          = err_q;

endmodule

// File: tb/tb_emif_avmm_arbiter.sv
// tb/tb_emif_avmm_arbiter.sv - self-checking bench for emif_avmm_arbiter
// Requester queues and an EMIF responder feed a per-cycle scoreboard of issue order and read return.
module tb_emif_avmm_arbiter;

  localparam int AW = 26;
  localparam int DW = 64;
  localparam int BW = 8;

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [BW-1:0] be;
  } cmd_t;

  typedef struct packed {
    logic          port;
    logic          rd;
    logic [AW-1:0] addr;
  } acc_t;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] data;
  } dlv_t;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] m_address   [2];
  logic          m_read      [2];
  logic          m_write     [2];
  logic [DW-1:0] m_writedata [2];
  logic [BW-1:0] m_byteenable[2];
  logic          m_wait      [2];
  logic [DW-1:0] m_rdata     [2];
  logic          m_rdv       [2];
  logic [AW-1:0] avs_address;
  logic          avs_read, avs_write;
  logic [DW-1:0] avs_writedata;
  logic [BW-1:0] avs_byteenable;
  logic [11:0]   avs_burstcount;
  logic          avs_waitrequest;
  logic [DW-1:0] avs_readdata;
  logic          avs_readdatavalid;
  logic [3:0]    rd_outstanding;
  logic          arb_err;

  emif_avmm_arbiter dut (
    .Clk_400(clk), .SoftReset_n(rst_n),
    .m0_address(m_address[0]), .m0_read(m_read[0]), .m0_write(m_write[0]),
    .m0_writedata(m_writedata[0]), .m0_byteenable(m_byteenable[0]),
    .m0_waitrequest(m_wait[0]), .m0_readdata(m_rdata[0]), .m0_readdatavalid(m_rdv[0]),
    .m1_address(m_address[1]), .m1_read(m_read[1]), .m1_write(m_write[1]),
    .m1_writedata(m_writedata[1]), .m1_byteenable(m_byteenable[1]),
    .m1_waitrequest(m_wait[1]), .m1_readdata(m_rdata[1]), .m1_readdatavalid(m_rdv[1]),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable), .avs_burstcount(avs_burstcount),
    .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .rd_outstanding(rd_outstanding), .arb_err(arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cmd_t          pend [2][$];
  logic          exp_tags[$];
  acc_t          acc_log[$];
  acc_t          exp_acc[$];
  dlv_t          dlv_log[$];
  dlv_t          exp_dlv[$];
  logic [DW-1:0] force_rsp[$];
  int            tests, fails;
  int            model_cnt, emif_pend, busy_pct, resp_pct, stall_left;
  logic          model_err;
  bit            gen_en;
  int            low_cnt[2];
  int            cmd_cycles, acc_cmd_cycle;
  bit            hold_valid, rsp_due;
  logic [127:0]  held;
  logic          rsp_port;
  logic [DW-1:0] rsp_data;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] avs_snap();
    return {16'h0, avs_read, avs_write, avs_address, avs_writedata, avs_byteenable, avs_burstcount};
  endfunction

  function automatic cmd_t mk(input logic rd, input logic wr, input logic [AW-1:0] a);
    cmd_t c;
    c.rd = rd; c.wr = wr; c.addr = a;
    c.wd = {32'hC0DE0000, 6'h0, a};
    c.be = 8'hFF;
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.rd   = 1'($urandom_range(1));
    c.wr   = ~c.rd;
    c.addr = AW'($urandom);
    c.wd   = {$urandom, $urandom};
    c.be   = BW'($urandom);
    return c;
  endfunction

  task automatic drive_reqs();
    cmd_t c;
    for (int n = 0; n < 2; n++) begin
      if (pend[n].size() > 0) c = pend[n][0];
      else c = '0;
      m_read[n] = c.rd; m_write[n] = c.wr; m_address[n] = c.addr;
      m_writedata[n] = c.wd; m_byteenable[n] = c.be;
    end
  endtask

  // One clock: check this cycle at the falling edge, then advance the model and drive the next cycle.
  task automatic cycle();
    logic acc [2];
    logic new_rd, new_port;
    cmd_t c;
    @(negedge clk);
    new_rd = 1'b0; new_port = 1'b0;
    if (avs_read || avs_write) cmd_cycles++;
    chk("wait_one_hot", 128'(!m_wait[0] && !m_wait[1]), 128'(0));
    for (int n = 0; n < 2; n++) begin
      acc[n] = 1'b0;
      if (!m_wait[n]) begin
        low_cnt[n]++;
        chk("wait_has_cmd", 128'(pend[n].size() > 0), 128'(1));
        if (pend[n].size() > 0) begin
          c = pend[n][0];
          chk("acc_cmd", avs_snap(), {16'h0, c.rd, c.wr & ~c.rd, c.addr, c.wd, c.be, 12'd1});
          chk("acc_ready", 128'(avs_waitrequest), 128'(0));
          acc_log.push_back({n[0], c.rd, c.addr});
          acc[n] = 1'b1;
          acc_cmd_cycle = cmd_cycles;
          if (c.rd) begin new_rd = 1'b1; new_port = n[0]; emif_pend++; end
          if (c.rd && c.wr) model_err = 1'b1;
        end
      end
    end
    if (hold_valid) chk("avs_stable", avs_snap(), held);
    hold_valid = (avs_read || avs_write) && avs_waitrequest;
    held = avs_snap();
    for (int n = 0; n < 2; n++) if (m_rdv[n]) dlv_log.push_back({n[0], m_rdata[n]});
    if (rsp_due) begin
      chk("rdv_owner", 128'(m_rdv[rsp_port]), 128'(1));
      chk("rdata", 128'(m_rdata[rsp_port]), 128'(rsp_data));
      chk("rdv_other", 128'(m_rdv[!rsp_port]), 128'(0));
    end else begin
      chk("rdv_idle", 128'({m_rdv[1], m_rdv[0]}), 128'(0));
    end
    chk("rd_outstanding", 128'(rd_outstanding), 128'(model_cnt));
    chk("arb_err", 128'(arb_err), 128'(model_err));
    rsp_due = 1'b0;
    if (avs_readdatavalid) begin
      if (exp_tags.size() > 0) begin
        rsp_port = exp_tags.pop_front();
        rsp_data = avs_readdata;
        rsp_due  = 1'b1;
        model_cnt--;
      end else begin
        model_err = 1'b1;
      end
    end
    if (new_rd) begin exp_tags.push_back(new_port); model_cnt++; end

    @(posedge clk); #1;
    for (int n = 0; n < 2; n++) if (acc[n]) void'(pend[n].pop_front());
    if (gen_en)
      for (int n = 0; n < 2; n++)
        if (pend[n].size() < 3 && $urandom_range(3) == 0) pend[n].push_back(rand_cmd());
    drive_reqs();
    if ((avs_read || avs_write) && stall_left > 0) begin
      avs_waitrequest = 1'b1;
      stall_left--;
    end else begin
      avs_waitrequest = (int'($urandom_range(99)) < busy_pct);
    end
    if (force_rsp.size() > 0) begin
      avs_readdatavalid = 1'b1;
      avs_readdata = force_rsp.pop_front();
      if (emif_pend > 0) emif_pend--;
    end else if (emif_pend > 0 && int'($urandom_range(99)) < resp_pct) begin
      avs_readdatavalid = 1'b1;
      avs_readdata = {$urandom, $urandom};
      emif_pend--;
    end else begin
      avs_readdatavalid = 1'b0;
      avs_readdata = '0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_logs();
    acc_log.delete(); exp_acc.delete(); dlv_log.delete(); exp_dlv.delete();
    low_cnt[0] = 0; low_cnt[1] = 0; cmd_cycles = 0; acc_cmd_cycle = 0;
  endtask

  task automatic chk_acc(input string tag);
    chk({tag, "_count"}, 128'(acc_log.size()), 128'(exp_acc.size()));
    for (int i = 0; i < exp_acc.size(); i++)
      if (i < acc_log.size()) chk(tag, 128'(acc_log[i]), 128'(exp_acc[i]));
  endtask

  task automatic chk_dlv(input string tag);
    chk({tag, "_count"}, 128'(dlv_log.size()), 128'(exp_dlv.size()));
    for (int i = 0; i < exp_dlv.size(); i++)
      if (i < dlv_log.size()) chk(tag, 128'(dlv_log[i]), 128'(exp_dlv[i]));
  endtask

  // Assert reset between clock edges and check every output while it is held.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_avs", avs_snap(), 128'(0));
    chk("rst_wait", 128'({m_wait[1], m_wait[0]}), 128'(3));
    chk("rst_rdv", 128'({m_rdv[1], m_rdv[0]}), 128'(0));
    chk("rst_rdata", {m_rdata[1], m_rdata[0]}, 128'(0));
    chk("rst_cnt", 128'(rd_outstanding), 128'(0));
    chk("rst_err", 128'(arb_err), 128'(0));
    pend[0].delete(); pend[1].delete(); exp_tags.delete(); force_rsp.delete();
    model_cnt = 0; model_err = 1'b0; emif_pend = 0; stall_left = 0;
    hold_valid = 1'b0; rsp_due = 1'b0;
    drive_reqs();
    avs_waitrequest = 1'b0; avs_readdatavalid = 1'b0; avs_readdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    tests = 0; fails = 0; rst_n = 1'b1;
    gen_en = 1'b0; busy_pct = 0; resp_pct = 0;
    rsp_port = 1'b0; rsp_data = '0; held = '0;
    clear_logs();
    do_reset();

    // Simultaneous writes alternate, m0 first.
    pend[0].push_back(mk(0, 1, 26'h10)); pend[0].push_back(mk(0, 1, 26'h11));
    pend[1].push_back(mk(0, 1, 26'h20)); pend[1].push_back(mk(0, 1, 26'h21));
    drive_reqs();
    run(12);
    exp_acc.push_back({1'b0, 1'b0, 26'h10}); exp_acc.push_back({1'b1, 1'b0, 26'h20});
    exp_acc.push_back({1'b0, 1'b0, 26'h11}); exp_acc.push_back({1'b1, 1'b0, 26'h21});
    chk_acc("rr_writes");
    chk("rr_low0", 128'(low_cnt[0]), 128'(2));
    chk("rr_low1", 128'(low_cnt[1]), 128'(2));

    // Interleaved reads return to their owners in issue order.
    clear_logs();
    pend[0].push_back(mk(1, 0, 26'h1)); pend[0].push_back(mk(1, 0, 26'h2));
    pend[0].push_back(mk(1, 0, 26'h3)); pend[1].push_back(mk(1, 0, 26'h4));
    drive_reqs();
    run(15);
    exp_acc.push_back({1'b0, 1'b1, 26'h1}); exp_acc.push_back({1'b1, 1'b1, 26'h4});
    exp_acc.push_back({1'b0, 1'b1, 26'h2}); exp_acc.push_back({1'b0, 1'b1, 26'h3});
    chk_acc("rd_issue");
    chk("rd_out4", 128'(rd_outstanding), 128'(4));
    force_rsp.push_back(64'hAAAA_0000_0000_000A); force_rsp.push_back(64'hBBBB_0000_0000_000B);
    force_rsp.push_back(64'hCCCC_0000_0000_000C); force_rsp.push_back(64'hDDDD_0000_0000_000D);
    run(8);
    exp_dlv.push_back({1'b0, 64'hAAAA_0000_0000_000A}); exp_dlv.push_back({1'b1, 64'hBBBB_0000_0000_000B});
    exp_dlv.push_back({1'b0, 64'hCCCC_0000_0000_000C}); exp_dlv.push_back({1'b0, 64'hDDDD_0000_0000_000D});
    chk_dlv("rd_return");

    // Ninth read stalls on a full tag FIFO until one response frees a slot.
    clear_logs();
    for (int i = 0; i < 9; i++) pend[0].push_back(mk(1, 0, AW'(32'h100 + i)));
    drive_reqs();
    run(40);
    chk("full_issued", 128'(acc_log.size()), 128'(8));
    chk("full_cnt", 128'(rd_outstanding), 128'(8));
    chk("full_stalled", 128'(pend[0].size()), 128'(1));
    force_rsp.push_back(64'h1234_5678_9ABC_DEF0);
    run(6);
    chk("full_issued9", 128'(acc_log.size()), 128'(9));
    chk("full_cnt8", 128'(rd_outstanding), 128'(8));
    for (int i = 0; i < 8; i++) force_rsp.push_back(64'(i) + 64'h5000);
    run(14);
    chk("full_drained", 128'(rd_outstanding), 128'(0));
    chk("full_returns", 128'(dlv_log.size()), 128'(9));

    // EMIF backpressure for 5 cycles: command held 6 cycles, accepted in the 6th.
    clear_logs();
    stall_left = 5;
    pend[0].push_back(mk(1, 0, 26'h55));
    drive_reqs();
    run(10);
    chk("stall_cmd_cycles", 128'(cmd_cycles), 128'(6));
    chk("stall_acc_cycle", 128'(acc_cmd_cycle), 128'(6));
    chk("stall_low0", 128'(low_cnt[0]), 128'(1));
    force_rsp.push_back(64'h55);
    run(3);

    // Response with no outstanding read is dropped and flags a sticky error.
    clear_logs();
    force_rsp.push_back(64'hDEAD_BEEF);
    run(4);
    chk("orphan_err", 128'(arb_err), 128'(1));
    chk("orphan_no_rdv", 128'(dlv_log.size()), 128'(0));
    run(3);
    chk("orphan_sticky", 128'(arb_err), 128'(1));

    // Reset with reads in flight, then m0 wins first again.
    clear_logs();
    pend[0].push_back(mk(1, 0, 26'h30)); pend[0].push_back(mk(1, 0, 26'h31));
    pend[0].push_back(mk(1, 0, 26'h32));
    drive_reqs();
    run(12);
    chk("pre_rst_cnt", 128'(rd_outstanding), 128'(3));
    do_reset();
    clear_logs();
    pend[0].push_back(mk(0, 1, 26'h40)); pend[1].push_back(mk(0, 1, 26'h41));
    drive_reqs();
    run(8);
    exp_acc.push_back({1'b0, 1'b0, 26'h40}); exp_acc.push_back({1'b1, 1'b0, 26'h41});
    chk_acc("post_rst");

    // Randomised traffic against the scoreboard, then drain.
    clear_logs();
    gen_en = 1'b1; busy_pct = 30; resp_pct = 25;
    run(2000);
    gen_en = 1'b0; busy_pct = 0; resp_pct = 60;
    for (int i = 0; i < 500 && (pend[0].size() + pend[1].size() + emif_pend) > 0; i++) cycle();
    run(3);
    chk("rand_drained", 128'(pend[0].size() + pend[1].size() + emif_pend), 128'(0));
    chk("rand_cnt0", 128'(rd_outstanding), 128'(0));

    // Read and write together is issued as a read and flags an error.
    do_reset();
    clear_logs();
    pend[0].push_back(mk(1, 1, 26'h77));
    drive_reqs();
    run(4);
    exp_acc.push_back({1'b0, 1'b1, 26'h77});
    chk_acc("rdwr_as_read");
    chk("rdwr_err", 128'(arb_err), 128'(1));
    force_rsp.push_back(64'h77);
    run(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/emif_avmm_arbiter.md
EMIF_AVMM_ARBITER -- requirements
Module: emif_avmm_arbiter

Interface
REQ-001 SHALL have parameter RD_DEPTH, default 8, meaning the maximum number of outstanding reads (tag FIFO depth).
REQ-002 SHALL have parameter ADDR_W, default 26, meaning the Avalon word-address width.
REQ-003 SHALL have parameter DATA_W, default 64, meaning the data width (byteenable width is DATA_W/8).
REQ-004 SHALL have port Clk_400  in  1  sole clock; all logic is rising-edge.
REQ-005 SHALL have port SoftReset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports mN_address  in  ADDR_W, mN_read  in  1, mN_write  in  1, mN_writedata  in  DATA_W, mN_byteenable  in  DATA_W/8, for N=0,1: requester commands.
REQ-007 SHALL have ports mN_waitrequest  out  1, mN_readdata  out  DATA_W, mN_readdatavalid  out  1, for N=0,1: requester responses.
REQ-008 SHALL have ports avs_address  out  ADDR_W, avs_read  out  1, avs_write  out  1, avs_writedata  out  DATA_W, avs_byteenable  out  DATA_W/8, avs_burstcount  out  12: the EMIF command.
REQ-009 SHALL have ports avs_waitrequest  in  1, avs_readdata  in  DATA_W, avs_readdatavalid  in  1: EMIF responses.
REQ-010 SHALL have ports rd_outstanding  out  $clog2(RD_DEPTH)+1 (live tag count) and arb_err  out  1 (sticky protocol error).

Function
REQ-011 SHALL implement the FSM states IDLE and HOLD, with an owner register (0/1) and a last_grant register.
REQ-012 IDLE: when either mN_read or mN_write is asserted and eligible, SHALL register the winner's command onto avs_* on that edge, set owner, set last_grant=owner, and go to HOLD.
REQ-013 Arbitration SHALL be round-robin: if both requesters are eligible, grant the one not equal to last_grant; a single eligible requester always wins.
REQ-014 A read request SHALL be eligible only while rd_outstanding < RD_DEPTH; write requests are always eligible.
REQ-015 HOLD: avs_* SHALL be held stable while avs_waitrequest=1; the command is accepted in the cycle where avs_waitrequest=0, and then avs_read/avs_write are deasserted and the FSM returns to IDLE (minimum 2 cycles per command).
REQ-016 mN_waitrequest SHALL be 1 except, combinationally, in the acceptance cycle when owner==N; requesters hold their command stable until that cycle.
REQ-017 avs_burstcount SHALL be constant 12'd1 whenever avs_read or avs_write is asserted; only single-beat transfers are supported.
REQ-018 A requester asserting both read and write SHALL be treated as a read and SHALL set arb_err.
REQ-019 On read acceptance, the owner ID SHALL be pushed into the RD_DEPTH-entry tag FIFO.
REQ-020 On avs_readdatavalid=1, the FIFO head SHALL be popped, and on the next cycle mHEAD_readdata = registered avs_readdata and mHEAD_readdatavalid is pulsed for 1 cycle; the other port's readdatavalid stays 0.
REQ-021 A simultaneous push and pop SHALL leave rd_outstanding unchanged; the FIFO pointers wrap modulo RD_DEPTH.
REQ-022 avs_readdatavalid with an empty FIFO SHALL drop the data, generate no mN_readdatavalid, and set arb_err.
REQ-023 Read responses SHALL return in issue order; no reordering.
REQ-024 Write responses SHALL be ignored; writes are not tracked.

Reset
REQ-025 On SoftReset_n=0, the following SHALL apply immediately (asynchronously): state=IDLE, last_grant=1 (m0 wins first), FIFO empty, rd_outstanding=0, arb_err=0, avs_read=avs_write=0, avs_address/avs_writedata/avs_byteenable=0, avs_burstcount=0, mN_readdatavalid=0, mN_readdata=0, mN_waitrequest=1.
REQ-026 Reset asserted mid-transaction SHALL abandon the held command and discard outstanding tags; responses arriving after reset release with an empty FIFO fall under REQ-022.
REQ-027 Reset deassertion SHALL take effect on the first rising edge of Clk_400 after release.

Verification
REQ-028 Both requesters issue a write simultaneously at addresses 0x10 and 0x20, with avs_waitrequest=0 -> m0's write to 0x10 is issued first, then m1's to 0x20, and each mN_waitrequest is low for exactly 1 cycle.
REQ-029 m0 issues reads to addresses 1, 2, 3 and m1 issues a read to 4, interleaved; EMIF returns data A, B, C, D in order -> each datum arrives at its own requester exactly 1 cycle after its avs_readdatavalid, in the issue order recorded in the tag FIFO.
REQ-030 m0 streams 9 reads with no EMIF responses -> the 9th read stalls while rd_outstanding=8; one readdatavalid -> the 9th read issues and rd_outstanding returns to 8.
REQ-031 Issue a read while avs_waitrequest=1 for 5 cycles -> avs_* stays stable for all 6 cycles, and m0_waitrequest drops only in cycle 6.
REQ-032 Pulse avs_readdatavalid with the FIFO empty -> arb_err=1 and stays 1, and no mN_readdatavalid is generated.
REQ-033 Assert SoftReset_n=0 with 3 reads outstanding -> rd_outstanding=0 and all outputs match REQ-025 in the same cycle; after release, m0 is granted first.
